// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// Grants one requester, launches its byte, then holds ownership until done or watchdog expiry.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned TIMEOUT   = 200000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_i,
  input  logic [NUM_REQ*DATA_BITS-1:0]   data_i,
  output logic [NUM_REQ-1:0]             gnt_o,
  output logic                           done_o,
  output logic                           err_o,
  output logic                           busy_o,
  output logic [$clog2(NUM_REQ)-1:0]     owner_o,
  output logic                           tx_en_o,
  output logic [DATA_BITS-1:0]           tx_data_o,
  input  logic                           tx_done_i
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [IW-1:0]          r_ptr, w_ptr_nxt;
  logic [CW-1:0]          r_cnt, w_cnt_nxt;
  logic [NUM_REQ-1:0]     r_gnt, w_gnt_nxt;
  logic                   r_done, w_done_nxt;
  logic                   r_err, w_err_nxt;
  logic                   r_busy, w_busy_nxt;
  logic [IW-1:0]          r_owner, w_owner_nxt;
  logic                   r_tx_en, w_tx_en_nxt;
  logic [DATA_BITS-1:0]   r_tx_data, w_tx_data_nxt;

  logic [DATA_BITS-1:0]   w_bytes [NUM_REQ];
  logic                   w_found;
  logic [IW-1:0]          w_win;
  logic [IW-1:0]          w_idx;

  // Unpack the producer bytes so the winner can be selected by index
  always_comb begin
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      w_bytes[k] = data_i[k*DATA_BITS +: DATA_BITS];
    end
  end

  // First pending requester at or after the pointer, wrapping upward
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      w_idx = IW'((int'(r_ptr) + i) % int'(NUM_REQ));
      if (!w_found && req_i[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_cnt_nxt     = r_cnt;
    w_gnt_nxt     = '0;
    w_done_nxt    = 1'b0;
    w_err_nxt     = 1'b0;
    w_busy_nxt    = r_busy;
    w_owner_nxt   = r_owner;
    w_tx_en_nxt   = 1'b0;
    w_tx_data_nxt = r_tx_data;

    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_tx_data_nxt = w_bytes[w_win];
          w_owner_nxt   = w_win;
          w_gnt_nxt     = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win;
          w_tx_en_nxt   = 1'b1;
          w_busy_nxt    = 1'b1;
          w_ptr_nxt     = IW'((int'(w_win) + 1) % int'(NUM_REQ));
          w_cnt_nxt     = '0;
          w_state_nxt   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt != CW'(TIMEOUT)) begin
          w_cnt_nxt = CW'(r_cnt + 1'b1);
        end
        // A done pulse during the launch cycle belongs to an earlier frame
        if (tx_done_i && !r_tx_en) begin
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end else if (r_cnt == CW'(TIMEOUT)) begin
          w_err_nxt   = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_gnt     <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
      r_owner   <= '0;
      r_tx_en   <= 1'b0;
      r_tx_data <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_gnt     <= w_gnt_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
      r_busy    <= w_busy_nxt;
      r_owner   <= w_owner_nxt;
      r_tx_en   <= w_tx_en_nxt;
      r_tx_data <= w_tx_data_nxt;
    end
  end

  assign gnt_o     = r_gnt;
  assign done_o    = r_done;
  assign err_o     = r_err;
  assign busy_o    = r_busy;
  assign owner_o   = r_owner;
  assign tx_en_o   = r_tx_en;
  assign tx_data_o = r_tx_data;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: table of arbitration transactions plus
// a hand-written mid-frame reset sequence. The transmitter is emulated via tx_done_i.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int DB = 8;
  localparam int TO = 20;
  localparam logic [31:0] STD = 32'h1312_1110;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NR-1:0]   req_i = '0;
  logic [NR*DB-1:0] data_i = '0;
  logic [NR-1:0]   gnt_o;
  logic            done_o;
  logic            err_o;
  logic            busy_o;
  logic [1:0]      owner_o;
  logic            tx_en_o;
  logic [DB-1:0]   tx_data_o;
  logic            tx_done_i = 1'b0;

  int errors = 0;
  int checks = 0;

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_BITS(DB), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_i),
    .data_i    (data_i),
    .gnt_o     (gnt_o),
    .done_o    (done_o),
    .err_o     (err_o),
    .busy_o    (busy_o),
    .owner_o   (owner_o),
    .tx_en_o   (tx_en_o),
    .tx_data_o (tx_data_o),
    .tx_done_i (tx_done_i)
  );

  always #10 clk = ~clk;

  // dly: cycles after launch at which tx_done_i pulses; 0 means never (watchdog)
  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    int          own;
    logic [7:0]  txd;
    int          dly;
    bit          stale;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_gnt(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt_o == '0 && n < 10);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " gnt"},     32'(gnt_o),     32'h0);
    chk({tag, " done"},    32'(done_o),    32'h0);
    chk({tag, " err"},     32'(err_o),     32'h0);
    chk({tag, " busy"},    32'(busy_o),    32'h0);
    chk({tag, " tx_en"},   32'(tx_en_o),   32'h0);
    chk({tag, " tx_data"}, 32'(tx_data_o), 32'h0);
    chk({tag, " owner"},   32'(owner_o),   32'h0);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench timeout");
  end

  initial begin
    int    n;
    int    k;
    int    exp_end;
    bit    busy_ok;
    string t;

    vecs[0]  = '{4'b1111, STD,          0, 8'h10, 3,  1'b0};
    vecs[1]  = '{4'b1111, STD,          1, 8'h11, 5,  1'b1};
    vecs[2]  = '{4'b1111, STD,          2, 8'h12, 1,  1'b0};
    vecs[3]  = '{4'b1111, STD,          3, 8'h13, 4,  1'b0};
    vecs[4]  = '{4'b1111, STD,          0, 8'h10, 2,  1'b0};
    vecs[5]  = '{4'b0010, 32'h1312A510, 1, 8'hA5, 6,  1'b0};
    vecs[6]  = '{4'b1001, STD,          3, 8'h13, 2,  1'b0};
    vecs[7]  = '{4'b1001, STD,          0, 8'h10, 2,  1'b0};
    vecs[8]  = '{4'b1001, STD,          3, 8'h13, 2,  1'b0};
    vecs[9]  = '{4'b0100, STD,          2, 8'h12, 0,  1'b0};
    vecs[10] = '{4'b0001, STD,          0, 8'h10, 3,  1'b0};
    vecs[11] = '{4'b0110, STD,          1, 8'h11, TO, 1'b0};

    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      t = $sformatf("v%0d", i);
      req_i  = vecs[i].req;
      data_i = vecs[i].data;
      wait_gnt(n);
      chk({t, " latency"}, 32'(n),          32'd1);
      chk({t, " gnt"},     32'(gnt_o),      32'(4'b0001 << vecs[i].own));
      chk({t, " tx_en"},   32'(tx_en_o),    32'h1);
      chk({t, " tx_data"}, 32'(tx_data_o),  32'(vecs[i].txd));
      chk({t, " owner"},   32'(owner_o),    32'(vecs[i].own));
      chk({t, " busy"},    32'(busy_o),     32'h1);
      chk({t, " prev_pulse"}, 32'({done_o, err_o}), 32'h0);

      req_i     = '0;
      tx_done_i = vecs[i].stale;
      exp_end   = (vecs[i].dly != 0) ? vecs[i].dly + 1 : TO + 1;
      busy_ok   = 1'b1;
      k         = 0;
      while (1) begin
        @(negedge clk);
        k++;
        tx_done_i = 1'b0;
        if (k == 1) begin
          chk({t, " gnt_width"},   32'(gnt_o),   32'h0);
          chk({t, " tx_en_width"}, 32'(tx_en_o), 32'h0);
        end
        if (done_o || err_o || k >= 40) break;
        if (!busy_o) busy_ok = 1'b0;
        if (k == vecs[i].dly) tx_done_i = 1'b1;
      end
      chk({t, " end_cycle"}, 32'(k),       32'(exp_end));
      chk({t, " done"},      32'(done_o),  32'(vecs[i].dly != 0));
      chk({t, " err"},       32'(err_o),   32'(vecs[i].dly == 0));
      chk({t, " busy_end"},  32'(busy_o),  32'h0);
      chk({t, " owner_end"}, 32'(owner_o), 32'(vecs[i].own));
      chk({t, " busy_held"}, 32'(busy_ok), 32'h1);
    end

    // Reset in the middle of a frame, with the pointer left at a nonzero value
    req_i  = 4'b0100;
    data_i = STD;
    wait_gnt(n);
    chk("mid owner", 32'(owner_o), 32'd2);
    req_i = '0;
    repeat (3) @(negedge clk);
    chk("mid busy", 32'(busy_o), 32'h1);
    rst = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    @(negedge clk);
    rst   = 1'b1;
    req_i = 4'b1111;
    wait_gnt(n);
    chk("post_reset latency", 32'(n),         32'd1);
    chk("post_reset gnt",     32'(gnt_o),     32'h1);
    chk("post_reset owner",   32'(owner_o),   32'd0);
    chk("post_reset tx_data", 32'(tx_data_o), 32'h10);
    req_i = '0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
